uart_rx: RTL and testbench

//   UART receiver: the downstream peer of the tx serializer. Oversamples the

---
 rtl/uart_rx_if.sv | 19 +
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and strobes out.
// master = the receiver, slave = whatever consumes its bytes.
interface uart_rx_if;
    logic       i_uart_rx;
    logic       o_wr;
    logic [7:0] o_data;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        input  i_uart_rx,
        output o_wr, o_data, o_frame_err, o_busy
    );

    modport slave (
        output i_uart_rx,
        input  o_wr, o_data, o_frame_err, o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling,
// one-cycle o_wr / o_frame_err strobes.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 1563
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_wr;
    logic             r_frame_err;
    logic             w_busy;

    assign w_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= bus.i_uart_rx;
            r_sync2     <= r_sync1;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    // Half-bit wait re-checks the start bit, rejecting short glitches
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!r_sync2) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == BAUD_LAST) begin
                        r_cnt   <= '0;
                        r_shreg <= {r_sync2, r_shreg[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == BAUD_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_data  <= r_shreg;
                            r_wr    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) must not look like a new start bit
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_wr        = r_wr;
    assign bus.o_data      = r_data;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_busy      = w_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bench-side serializer drives frames,
// expected bytes come from a simple per-frame model.
module tb_uart_rx;
    logic clk;
    logic rst_n;

    uart_rx_if ifa ();
    uart_rx_if ifb ();

    uart_rx #(.CLOCKS_PER_BAUD(16))   dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    uart_rx #(.CLOCKS_PER_BAUD(1563)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // monitor: records every strobe seen on either receiver
    int       wr_a = 0, fe_a = 0, wr_b = 0, fe_b = 0;
    int       both_bad = 0, busy_bad = 0;
    logic [7:0] obs_a [0:255];
    logic [7:0] obs_b [0:255];

    always @(negedge clk) begin
        if (ifa.o_wr === 1'b1) begin
            obs_a[wr_a[7:0]] = ifa.o_data;
            wr_a = wr_a + 1;
            if (ifa.o_busy !== 1'b0) busy_bad = busy_bad + 1;
        end
        if (ifa.o_frame_err === 1'b1) fe_a = fe_a + 1;
        if (ifb.o_wr === 1'b1) begin
            obs_b[wr_b[7:0]] = ifb.o_data;
            wr_b = wr_b + 1;
            if (ifb.o_busy !== 1'b0) busy_bad = busy_bad + 1;
        end
        if (ifb.o_frame_err === 1'b1) fe_b = fe_b + 1;
        if (ifa.o_wr === 1'b1 && ifa.o_frame_err === 1'b1) both_bad = both_bad + 1;
        if (ifb.o_wr === 1'b1 && ifb.o_frame_err === 1'b1) both_bad = both_bad + 1;
    end

    // reference model: last byte delivered by a good frame on receiver A
    logic [7:0] last_good_a = 8'h00;

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) ifb.i_uart_rx = v; else ifa.i_uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop);
        int cpb;
        cpb = sel ? 1563 : 16;
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, logic'((b >> i) & 8'h01), cpb);
        drive(sel, stop, cpb);
    endtask

    task automatic wait_busy(input bit sel, input logic want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel ? ifb.o_busy : ifa.o_busy) === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.i_uart_rx = 1'b1;
        ifb.i_uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++; if (ifa.o_wr !== 1'b0) $display("FAIL reset_wr got %b exp 0", ifa.o_wr); else pass_cnt++;
        total_cnt++; if (ifa.o_frame_err !== 1'b0) $display("FAIL reset_fe got %b exp 0", ifa.o_frame_err); else pass_cnt++;
        total_cnt++; if (ifa.o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", ifa.o_busy); else pass_cnt++;
        total_cnt++; if (ifa.o_data !== 8'h00) $display("FAIL reset_data got %h exp 00", ifa.o_data); else pass_cnt++;
        total_cnt++; if (ifb.o_busy !== 1'b0) $display("FAIL reset_busy_b got %b exp 0", ifb.o_busy); else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int w0, f0;
        w0 = wr_a; f0 = fe_a;
        send_frame(1'b0, 8'h56, 1'b1);
        drive(1'b0, 1'b1, 10);
        last_good_a = 8'h56;
        total_cnt++; if (wr_a - w0 !== 1) $display("FAIL single_wr_count got %0d exp 1", wr_a - w0); else pass_cnt++;
        total_cnt++; if (obs_a[w0[7:0]] !== 8'h56) $display("FAIL single_data got %h exp 56", obs_a[w0[7:0]]); else pass_cnt++;
        total_cnt++; if (fe_a - f0 !== 0) $display("FAIL single_fe got %0d exp 0", fe_a - f0); else pass_cnt++;
        total_cnt++; if (ifa.o_data !== last_good_a) $display("FAIL single_hold got %h exp %h", ifa.o_data, last_good_a); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w0;
        logic [7:0] exp_q [$];
        w0 = wr_a;
        exp_q = '{8'h65, 8'hA5};
        foreach (exp_q[k]) send_frame(1'b0, exp_q[k], 1'b1);
        drive(1'b0, 1'b1, 10);
        last_good_a = 8'hA5;
        total_cnt++; if (wr_a - w0 !== 2) $display("FAIL b2b_wr_count got %0d exp 2", wr_a - w0); else pass_cnt++;
        foreach (exp_q[k]) begin
            total_cnt++;
            if (obs_a[(w0 + k) % 256] !== exp_q[k]) $display("FAIL b2b_byte%0d got %h exp %h", k, obs_a[(w0 + k) % 256], exp_q[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int w0, f0;
        bit ok;
        w0 = wr_a; f0 = fe_a;
        drive(1'b0, 1'b0, 4);
        wait_busy(1'b0, 1'b1, 8, ok);
        total_cnt++; if (!ok) $display("FAIL glitch_busy_rise got 0 exp 1 within 8 cycles"); else pass_cnt++;
        drive(1'b0, 1'b1, 1);
        wait_busy(1'b0, 1'b0, 40, ok);
        total_cnt++; if (!ok) $display("FAIL glitch_return_idle got busy exp idle within 40 cycles"); else pass_cnt++;
        drive(1'b0, 1'b1, 200);
        total_cnt++; if (wr_a - w0 !== 0) $display("FAIL glitch_wr got %0d exp 0", wr_a - w0); else pass_cnt++;
        total_cnt++; if (fe_a - f0 !== 0) $display("FAIL glitch_fe got %0d exp 0", fe_a - f0); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int w0, f0;
        bit ok;
        w0 = wr_a; f0 = fe_a;
        send_frame(1'b0, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 100);
        total_cnt++; if (fe_a - f0 !== 1) $display("FAIL ferr_count got %0d exp 1", fe_a - f0); else pass_cnt++;
        total_cnt++; if (wr_a - w0 !== 0) $display("FAIL ferr_wr got %0d exp 0", wr_a - w0); else pass_cnt++;
        total_cnt++; if (ifa.o_data !== last_good_a) $display("FAIL ferr_data got %h exp %h", ifa.o_data, last_good_a); else pass_cnt++;
        total_cnt++; if (ifa.o_busy !== 1'b1) $display("FAIL ferr_wait_busy got %b exp 1", ifa.o_busy); else pass_cnt++;
        drive(1'b0, 1'b1, 1);
        wait_busy(1'b0, 1'b0, 10, ok);
        total_cnt++; if (!ok) $display("FAIL ferr_release got busy exp idle within 10 cycles"); else pass_cnt++;
        drive(1'b0, 1'b1, 20);
        total_cnt++; if (fe_a - f0 !== 1 || wr_a - w0 !== 0) $display("FAIL ferr_after fe %0d wr %0d exp 1 0", fe_a - f0, wr_a - w0); else pass_cnt++;
    endtask

    task automatic test_random();
        int w0, gap;
        logic [7:0] exp_q [$];
        w0 = wr_a;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(8'($urandom));
            gap = $urandom_range(0, 20);
            send_frame(1'b0, exp_q[k], 1'b1);
            drive(1'b0, 1'b1, gap);
        end
        drive(1'b0, 1'b1, 10);
        last_good_a = exp_q[7];
        total_cnt++; if (wr_a - w0 !== 8) $display("FAIL rand_wr_count got %0d exp 8", wr_a - w0); else pass_cnt++;
        foreach (exp_q[k]) begin
            total_cnt++;
            if (obs_a[(w0 + k) % 256] !== exp_q[k]) $display("FAIL rand_byte%0d got %h exp %h", k, obs_a[(w0 + k) % 256], exp_q[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0, f0;
        logic [7:0] b;
        b = 8'hF0;
        w0 = wr_a; f0 = fe_a;
        drive(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1'b0, logic'((b >> i) & 8'h01), 16);
        drive(1'b0, 1'b1, 8);
        total_cnt++; if (ifa.o_busy !== 1'b1) $display("FAIL rmid_busy_before got %b exp 1", ifa.o_busy); else pass_cnt++;
        rst_n = 1'b0;
        ifa.i_uart_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        last_good_a = 8'h00;
        total_cnt++; if (ifa.o_busy !== 1'b0) $display("FAIL rmid_idle got %b exp 0", ifa.o_busy); else pass_cnt++;
        total_cnt++; if (ifa.o_data !== last_good_a) $display("FAIL rmid_data got %h exp %h", ifa.o_data, last_good_a); else pass_cnt++;
        drive(1'b0, 1'b1, 200);
        total_cnt++; if (wr_a - w0 !== 0 || fe_a - f0 !== 0) $display("FAIL rmid_strobe wr %0d fe %0d exp 0 0", wr_a - w0, fe_a - f0); else pass_cnt++;
        send_frame(1'b0, 8'h81, 1'b1);
        drive(1'b0, 1'b1, 10);
        last_good_a = 8'h81;
        total_cnt++; if (wr_a - w0 !== 1) $display("FAIL rmid_after_count got %0d exp 1", wr_a - w0); else pass_cnt++;
        total_cnt++; if (obs_a[w0[7:0]] !== 8'h81) $display("FAIL rmid_after_data got %h exp 81", obs_a[w0[7:0]]); else pass_cnt++;
    endtask

    task automatic test_loopback_slow();
        int w0, f0;
        logic [7:0] exp_q [$];
        w0 = wr_b; f0 = fe_b;
        exp_q = '{8'h56, 8'h65};
        foreach (exp_q[k]) send_frame(1'b1, exp_q[k], 1'b1);
        drive(1'b1, 1'b1, 20);
        total_cnt++; if (wr_b - w0 !== 2) $display("FAIL slow_wr_count got %0d exp 2", wr_b - w0); else pass_cnt++;
        total_cnt++; if (fe_b - f0 !== 0) $display("FAIL slow_fe got %0d exp 0", fe_b - f0); else pass_cnt++;
        foreach (exp_q[k]) begin
            total_cnt++;
            if (obs_b[(w0 + k) % 256] !== exp_q[k]) $display("FAIL slow_byte%0d got %h exp %h", k, obs_b[(w0 + k) % 256], exp_q[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_strobe_rules();
        total_cnt++; if (both_bad !== 0) $display("FAIL wr_and_ferr_together got %0d exp 0", both_bad); else pass_cnt++;
        total_cnt++; if (busy_bad !== 0) $display("FAIL busy_with_wr got %0d exp 0", busy_bad); else pass_cnt++;
    endtask

    initial begin
        ifa.i_uart_rx = 1'b1;
        ifb.i_uart_rx = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_random();
        test_reset_mid_frame();
        test_loopback_slow();
        test_strobe_rules();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
